mem_responder: RTL and testbench

- Memory-side responder for the CPU's MEM-stage handshake.
- Accepts the level request (en_mem plus address, data, size and direction) raised by the control sequencer and drives mem_wait back to it.
- Runs the access against a 16-bit synchronous RAM/peripheral port with programmable wait states and byte lanes.
- Sits between the CPU core and the on-chip memory; one outstanding access at a time.

---
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// MEM-stage responder: accepts a level request from the CPU sequencer, runs one access
// on a 16-bit synchronous RAM port with wait states and byte lanes. Optional MEM_ALIGN_TRAP_EN.
//
// state  | meaning
// IDLE   | no access; a request is accepted and latched here
// ACCESS | RAM strobe held with latched address/lanes/data until count expires and ram_ready
// DONE   | access complete, mem_wait low; waits for en_mem to drop
module mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_mem,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_wait,
    output logic [ADDR_W-2:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic [1:0]        ram_be,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_ready,
    output logic              mem_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        lane_rdata;
    logic              in_access;

    assign lane_rdata = addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0];

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (en_mem) begin
                    we_d    = mem_we;
                    byte_d  = mem_byte;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
`ifdef MEM_ALIGN_TRAP_EN
                    if (!mem_byte && mem_addr[0])
                        state_d = DONE;
                    else
`endif
                        state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                // completes even if en_mem dropped mid-access
                if (cnt_q == 4'd0 && ram_ready) begin
                    if (!we_q)
                        rdata_d = byte_q ? {8'h00, lane_rdata} : ram_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!en_mem)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ALIGN_TRAP_EN
    logic fault_q, fault_d;

    // one-cycle pulse coincident with the direct IDLE->DONE trap
    always_comb begin
        fault_d = (state_q == IDLE) && en_mem && !mem_byte && mem_addr[0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            fault_q <= 1'b0;
        else
            fault_q <= fault_d;
    end

    assign mem_fault = fault_q;
`else
    assign mem_fault = 1'b0;
`endif

    assign in_access = (state_q == ACCESS);
    assign ram_re    = in_access && !we_q;
    assign ram_we    = in_access && we_q;
    assign ram_be    = !in_access ? 2'b00 :
                       !byte_q    ? 2'b11 :
                       addr_q[0]  ? 2'b10 : 2'b01;
    assign ram_addr  = addr_q[ADDR_W-1:1];
    assign ram_wdata = byte_q ? {2{wdata_q[7:0]}} : wdata_q;
    assign mem_rdata = rdata_q;
    assign mem_wait  = en_mem && (state_q != DONE) && !rst;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES 0 and 3), a byte-array RAM model,
// and a reference memory image predicting read data, latency and lane behaviour.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        tb_init;
    logic        rst       [2];
    logic        en_mem    [2];
    logic        mem_we    [2];
    logic        mem_byte  [2];
    logic [15:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic        mem_wait  [2];
    logic [14:0] ram_addr  [2];
    logic [15:0] ram_wdata [2];
    logic [1:0]  ram_be    [2];
    logic        ram_we    [2];
    logic        ram_re    [2];
    logic [15:0] ram_rdata [2];
    logic        ram_ready [2];
    logic        mem_fault [2];

    logic [7:0]  ram_img [2][256];
    logic [7:0]  ref_img [2][256];
    logic [15:0] last_rd [2];
    int          wc [2] = '{0, 3};
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(0), .ADDR_W(16)) u_dut0 (
        .clk(clk), .rst(rst[0]), .en_mem(en_mem[0]), .mem_we(mem_we[0]),
        .mem_byte(mem_byte[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_wait(mem_wait[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_be(ram_be[0]), .ram_we(ram_we[0]), .ram_re(ram_re[0]),
        .ram_rdata(ram_rdata[0]), .ram_ready(ram_ready[0]), .mem_fault(mem_fault[0])
    );

    mem_responder #(.WAIT_CYCLES(3), .ADDR_W(16)) u_dut1 (
        .clk(clk), .rst(rst[1]), .en_mem(en_mem[1]), .mem_we(mem_we[1]),
        .mem_byte(mem_byte[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_wait(mem_wait[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_be(ram_be[1]), .ram_we(ram_we[1]), .ram_re(ram_re[1]),
        .ram_rdata(ram_rdata[1]), .ram_ready(ram_ready[1]), .mem_fault(mem_fault[1])
    );

    // RAM model: data only driven while read strobe and ready, otherwise a poison value
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ram_rdata[d] = 16'hDEAD;
            if (ram_re[d] && ram_ready[d])
                ram_rdata[d] = {ram_img[d][{ram_addr[d][6:0], 1'b1}],
                                ram_img[d][{ram_addr[d][6:0], 1'b0}]};
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tb_init) begin
                for (int i = 0; i < 256; i++)
                    ram_img[d][i] <= 8'((i * 7) + (d * 13) + 5);
            end else if (ram_we[d] && ram_ready[d]) begin
                if (ram_be[d][0]) ram_img[d][{ram_addr[d][6:0], 1'b0}] <= ram_wdata[d][7:0];
                if (ram_be[d][1]) ram_img[d][{ram_addr[d][6:0], 1'b1}] <= ram_wdata[d][15:8];
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full CPU request: raise en_mem, stall ready for `stall` access cycles,
    // hold en_mem `hold` cycles after completion, then drop it for one cycle.
    task automatic run_req(input int d, input bit we, input bit byt, input logic [15:0] addr,
                           input logic [15:0] wd, input int stall, input int hold);
        int          cyc, high, strobes, faults, wrong_kind, exp_high, big;
        bit          done, addr_ok, be_ok, wd_ok, hold_ok, prev_strobe, strobe, trap;
        logic [14:0] exp_ra;
        logic [1:0]  exp_be;
        logic [15:0] exp_wd, exp_rd;
        logic [7:0]  ia;
        trap = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
        trap = !byt && addr[0];
`endif
        exp_ra = addr[15:1];
        exp_be = byt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
        exp_wd = byt ? {wd[7:0], wd[7:0]} : wd;
        ia     = {addr[7:1], 1'b0};
        exp_rd = last_rd[d];
        if (!trap) begin
            if (!we) begin
                exp_rd = byt ? {8'h00, ref_img[d][addr[7:0]]}
                             : {ref_img[d][ia | 8'h01], ref_img[d][ia]};
                last_rd[d] = exp_rd;
            end else if (byt) begin
                ref_img[d][addr[7:0]] = wd[7:0];
            end else begin
                ref_img[d][ia]         = wd[7:0];
                ref_img[d][ia | 8'h01] = wd[15:8];
            end
        end
        big      = (stall > wc[d]) ? stall : wc[d];
        exp_high = trap ? 1 : 2 + big;

        en_mem[d] = 1'b1; mem_we[d] = we; mem_byte[d] = byt;
        mem_addr[d] = addr; mem_wdata[d] = wd;
        cyc = 0; high = 0; strobes = 0; faults = 0; wrong_kind = 0;
        done = 0; addr_ok = 1; be_ok = 1; wd_ok = 1; hold_ok = 1; prev_strobe = 0;
        while (!done && cyc < 64) begin
            ram_ready[d] = (cyc > stall);
            @(negedge clk);
            strobe = ram_we[d] || ram_re[d];
            if (strobe && !prev_strobe) strobes++;
            prev_strobe = strobe;
            if (strobe) begin
                if (ram_addr[d] !== exp_ra) addr_ok = 0;
                if (ram_be[d] !== exp_be) be_ok = 0;
                if (we && ram_wdata[d] !== exp_wd) wd_ok = 0;
                if (we ? ram_re[d] : ram_we[d]) wrong_kind++;
            end
            if (mem_fault[d]) faults++;
            if (mem_wait[d]) high++;
            else done = 1;
            step();
            cyc++;
        end
        chk_eq($sformatf("done[%0d]", d), done, 1);
        ram_ready[d] = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (mem_wait[d] || ram_we[d] || ram_re[d]) hold_ok = 0;
            if (mem_fault[d]) faults++;
            step();
        end
        en_mem[d] = 1'b0;
        @(negedge clk);
        if (ram_we[d] || ram_re[d]) hold_ok = 0;
        if (mem_fault[d]) faults++;
        step();
        chk_eq($sformatf("lat[%0d]", d), high, exp_high);
        chk_eq($sformatf("strobes[%0d]", d), strobes, trap ? 0 : 1);
        chk_eq($sformatf("fault[%0d]", d), faults, trap ? 1 : 0);
        chk_eq($sformatf("kind[%0d]", d), wrong_kind, 0);
        chk_eq($sformatf("ram_addr[%0d]", d), addr_ok, 1);
        chk_eq($sformatf("ram_be[%0d]", d), be_ok, 1);
        chk_eq($sformatf("ram_wdata[%0d]", d), wd_ok, 1);
        chk_eq($sformatf("hold[%0d]", d), hold_ok, 1);
        chk_eq($sformatf("rdata[%0d]", d), mem_rdata[d], exp_rd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; en_mem[d] = 1'b1; mem_we[d] = 1'b0; mem_byte[d] = 1'b0;
            mem_addr[d] = 16'h0; mem_wdata[d] = 16'h0; ram_ready[d] = 1'b1;
            last_rd[d] = 16'h0000;
            for (int i = 0; i < 256; i++) ref_img[d][i] = 8'((i * 7) + (d * 13) + 5);
        end
        step();
        step();
        @(negedge clk);
        chk_eq("wait_in_rst", mem_wait[0], 0);
        step();
        tb_init = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            en_mem[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("rst_we[%0d]", d), ram_we[d], 0);
            chk_eq($sformatf("rst_re[%0d]", d), ram_re[d], 0);
            chk_eq($sformatf("rst_be[%0d]", d), ram_be[d], 0);
            chk_eq($sformatf("rst_rdata[%0d]", d), mem_rdata[d], 16'h0000);
            chk_eq($sformatf("rst_fault[%0d]", d), mem_fault[d], 0);
            chk_eq($sformatf("rst_wait[%0d]", d), mem_wait[d], 0);
        end
        step();

        // directed cases, zero wait states
        run_req(0, 1, 0, 16'h0010, 16'hBEEF, 0, 0);
        run_req(0, 0, 0, 16'h0010, 16'h0000, 0, 0);
        chk_eq("beef", mem_rdata[0], 16'hBEEF);
        run_req(0, 1, 0, 16'h0010, 16'hA55A, 0, 0);
        run_req(0, 0, 1, 16'h0011, 16'h0000, 0, 0);
        chk_eq("byte_hi", mem_rdata[0], 16'h00A5);
        run_req(0, 0, 1, 16'h0010, 16'h0000, 0, 0);
        chk_eq("byte_lo", mem_rdata[0], 16'h005A);
        run_req(0, 1, 1, 16'h0021, 16'h773C, 0, 0);
        run_req(0, 0, 0, 16'h0020, 16'h0000, 0, 4);
        run_req(0, 1, 0, 16'h0003, 16'h1234, 0, 1);
        run_req(0, 0, 0, 16'h0002, 16'h0000, 0, 0);

        // directed cases, three wait states with ready stretch
        run_req(1, 0, 0, 16'h0030, 16'h0000, 5, 0);
        run_req(1, 1, 1, 16'h0031, 16'h00C3, 2, 2);
        run_req(1, 0, 1, 16'h0031, 16'h0000, 0, 0);

        // reset during the second access cycle
        en_mem[1] = 1'b1; mem_we[1] = 1'b0; mem_byte[1] = 1'b0;
        mem_addr[1] = 16'h0040; ram_ready[1] = 1'b1;
        step();
        step();
        rst[1] = 1'b1;
        @(negedge clk);
        chk_eq("wait_rst_mid", mem_wait[1], 0);
        step();
        rst[1] = 1'b0;
        en_mem[1] = 1'b0;
        last_rd[1] = 16'h0000;
        @(negedge clk);
        chk_eq("rst_mid_re", ram_re[1], 0);
        chk_eq("rst_mid_be", ram_be[1], 0);
        chk_eq("rst_mid_rdata", mem_rdata[1], 16'h0000);
        step();
        run_req(1, 0, 0, 16'h0040, 16'h0000, 0, 0);

        // randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                run_req(d, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                        int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
